// File: rtl/shift_sched_if.sv
// Request channel of one shift_sched requester port: valid/ready handshake plus shift operands.
interface shift_sched_if #(
  parameter int unsigned TagW = 4
) ();
  logic            valid;
  logic            ready;
  logic [31:0]     x;
  logic [4:0]      s;
  logic            left;
  logic            log;
  logic [TagW-1:0] tag;

  modport master (output valid, x, s, left, log, tag, input ready);
  modport slave  (input valid, x, s, left, log, tag, output ready);
endinterface

// File: rtl/shift_sched.sv
// Two-port scheduler sharing one external ShiftLR; in-order tagged responses with backpressure.
// Define SHIFT_SCHED_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module shift_sched #(
  parameter int unsigned TagW  = 4,
  parameter int unsigned Depth = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  shift_sched_if.slave    a_if,
  shift_sched_if.slave    b_if,
  output logic [31:0]     sh_x_o,
  output logic [4:0]      sh_s_o,
  output logic            sh_left_o,
  output logic            sh_log_o,
  input  logic [31:0]     sh_z_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [31:0]     rsp_z_o,
  output logic            rsp_id_o,
  output logic [TagW-1:0] rsp_tag_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned OccW = CntW + 1;

  logic            push, pop, credit_ok, gnt_a, gnt_b, issue;
  logic [OccW-1:0] occ_after;

  logic [31:0]     sel_x;
  logic [4:0]      sel_s;
  logic            sel_left, sel_log;
  logic [TagW-1:0] sel_tag;

  logic [31:0]     sh_x_q;
  logic [4:0]      sh_s_q;
  logic            sh_left_q, sh_log_q;

  logic            inflight_q;
  logic            inf_id_q;
  logic [TagW-1:0] inf_tag_q;

  logic [31:0]     mem_z_q   [Depth];
  logic            mem_id_q  [Depth];
  logic [TagW-1:0] mem_tag_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CntW-1:0] count_q, count_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_z_q, rsp_z_d;
  logic            rsp_id_q, rsp_id_d;
  logic [TagW-1:0] rsp_tag_q, rsp_tag_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign push   = inflight_q;
  assign pop    = rsp_valid_q & rsp_ready_i;
  assign rd_nxt = ptr_inc(rd_ptr_q);

  // An issue now needs a slot for itself after the inflight op (if any) lands.
  assign occ_after = OccW'(count_q) + OccW'(inflight_q) - OccW'(pop);
  assign credit_ok = rst_ni & (occ_after < OccW'(Depth));

`ifdef SHIFT_SCHED_RR_EN
  logic prio_b_q;

  assign gnt_a = credit_ok & a_if.valid & (~b_if.valid | ~prio_b_q);
  assign gnt_b = credit_ok & b_if.valid & (~a_if.valid | prio_b_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_b_q <= 1'b0;
    end else if (gnt_a) begin
      prio_b_q <= 1'b1;
    end else if (gnt_b) begin
      prio_b_q <= 1'b0;
    end
  end
`else
  assign gnt_a = credit_ok & a_if.valid;
  assign gnt_b = credit_ok & b_if.valid & ~a_if.valid;
`endif

  assign issue      = gnt_a | gnt_b;
  assign a_if.ready = gnt_a;
  assign b_if.ready = gnt_b;

  assign sel_x    = gnt_b ? b_if.x    : a_if.x;
  assign sel_s    = gnt_b ? b_if.s    : a_if.s;
  assign sel_left = gnt_b ? b_if.left : a_if.left;
  assign sel_log  = gnt_b ? b_if.log  : a_if.log;
  assign sel_tag  = gnt_b ? b_if.tag  : a_if.tag;

  // Operands go straight to the shifter on issue; otherwise the last issued values are held.
  assign sh_x_o    = issue ? sel_x    : sh_x_q;
  assign sh_s_o    = issue ? sel_s    : sh_s_q;
  assign sh_left_o = issue ? sel_left : sh_left_q;
  assign sh_log_o  = issue ? sel_log  : sh_log_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_x_q     <= '0;
      sh_s_q     <= '0;
      sh_left_q  <= 1'b0;
      sh_log_q   <= 1'b0;
      inflight_q <= 1'b0;
      inf_id_q   <= 1'b0;
      inf_tag_q  <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        sh_x_q    <= sel_x;
        sh_s_q    <= sel_s;
        sh_left_q <= sel_left;
        sh_log_q  <= sel_log;
        inf_id_q  <= gnt_b;
        inf_tag_q <= sel_tag;
      end
    end
  end

  always_comb begin
    count_d     = count_q + CntW'(push) - CntW'(pop);
    rsp_valid_d = (count_d != '0);
    rsp_z_d     = rsp_z_q;
    rsp_id_d    = rsp_id_q;
    rsp_tag_d   = rsp_tag_q;
    // Head register takes the landing result when the FIFO is (or becomes) otherwise empty.
    if (push && ((count_q == '0) || ((count_q == CntW'(1)) && pop))) begin
      rsp_z_d   = sh_z_i;
      rsp_id_d  = inf_id_q;
      rsp_tag_d = inf_tag_q;
    end else if (pop && (count_q > CntW'(1))) begin
      rsp_z_d   = mem_z_q[rd_nxt];
      rsp_id_d  = mem_id_q[rd_nxt];
      rsp_tag_d = mem_tag_q[rd_nxt];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_z_q[i]   <= '0;
        mem_id_q[i]  <= 1'b0;
        mem_tag_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_id_q    <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      if (push) begin
        mem_z_q[wr_ptr_q]   <= sh_z_i;
        mem_id_q[wr_ptr_q]  <= inf_id_q;
        mem_tag_q[wr_ptr_q] <= inf_tag_q;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= rd_nxt;
      end
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_z_o     = rsp_z_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_tag_o   = rsp_tag_q;

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched with a behavioural ShiftLR (registered inputs, combinational Z).
module tb_shift_sched;
  localparam int unsigned TagW  = 4;
  localparam int unsigned Depth = 2;
`ifdef SHIFT_SCHED_RR_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_sched_if #(.TagW(TagW)) a_if ();
  shift_sched_if #(.TagW(TagW)) b_if ();

  logic [31:0]     sh_x, sh_z, rsp_z;
  logic [4:0]      sh_s;
  logic            sh_left, sh_log, rsp_valid, rsp_ready, rsp_id;
  logic [TagW-1:0] rsp_tag;

  shift_sched #(.TagW(TagW), .Depth(Depth)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .a_if        (a_if),
    .b_if        (b_if),
    .sh_x_o      (sh_x),
    .sh_s_o      (sh_s),
    .sh_left_o   (sh_left),
    .sh_log_o    (sh_log),
    .sh_z_i      (sh_z),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_z_o     (rsp_z),
    .rsp_id_o    (rsp_id),
    .rsp_tag_o   (rsp_tag)
  );

  // External ShiftLR: operands latched at the clock edge, result combinational from the latch.
  logic [31:0] m_x;
  logic [4:0]  m_s;
  logic        m_left, m_log;
  always_ff @(posedge clk) begin
    m_x    <= sh_x;
    m_s    <= sh_s;
    m_left <= sh_left;
    m_log  <= sh_log;
  end
  always_comb begin
    if (m_left)     sh_z = m_x << m_s;
    else if (m_log) sh_z = m_x >> m_s;
    else            sh_z = 32'($signed(m_x) >>> m_s);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit port_b, input logic [31:0] x, input logic [4:0] s,
                       input logic left, input logic lg, input logic [TagW-1:0] tag);
    if (port_b) begin
      b_if.valid = 1'b1; b_if.x = x; b_if.s = s; b_if.left = left; b_if.log = lg; b_if.tag = tag;
    end else begin
      a_if.valid = 1'b1; a_if.x = x; a_if.s = s; a_if.left = left; a_if.log = lg; a_if.tag = tag;
    end
  endtask

  // One op on an empty scheduler with rsp_ready=1; called at posedge+1, returns at posedge+1.
  task automatic op_check(input string name, input bit port_b, input logic [31:0] x,
                          input logic [4:0] s, input logic left, input logic lg,
                          input logic [TagW-1:0] tag, input logic [31:0] exp_z);
    drive(port_b, x, s, left, lg, tag);
    @(negedge clk);
    check({name, "_ready"}, 32'(port_b ? b_if.ready : a_if.ready), 32'd1);
    check({name, "_sh_x"}, sh_x, x);
    @(posedge clk); #1;
    a_if.valid = 1'b0;
    b_if.valid = 1'b0;
    @(negedge clk);
    check({name, "_lat1_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check({name, "_lat2_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_z"}, rsp_z, exp_z);
    check({name, "_id"}, 32'(rsp_id), 32'(port_b));
    check({name, "_tag"}, 32'(rsp_tag), 32'(tag));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic        ar, br, exp_b, exp_id;
  logic [31:0] bp_z   [3];
  logic        bp_id  [3];
  logic [3:0]  bp_tag [3];

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    drive(1'b0, 32'hDEAD_BEEF, 5'd3, 1'b1, 1'b0, 4'd1);
    b_if.valid = 1'b0; b_if.x = '0; b_if.s = '0; b_if.left = 1'b0; b_if.log = 1'b0;
    b_if.tag = '0;
    repeat (2) @(negedge clk);
    check("rst_a_ready", 32'(a_if.ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_sh_x", sh_x, 32'd0);
    check("rst_rsp_z", rsp_z, 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_if.valid = 1'b0;
    rsp_ready = 1'b1;

    op_check("single", 1'b0, 32'h8000_0000, 5'd4, 1'b0, 1'b0, 4'd3, 32'hF800_0000);
    check("sh_hold", sh_x, 32'h8000_0000);
    op_check("left0", 1'b1, 32'h1234_5678, 5'd0, 1'b1, 1'b0, 4'd5, 32'h1234_5678);
    op_check("left31", 1'b1, 32'h0000_0001, 5'd31, 1'b1, 1'b0, 4'd6, 32'h8000_0000);
    op_check("lsr28", 1'b1, 32'hF000_0000, 5'd28, 1'b0, 1'b1, 4'd7, 32'h0000_000F);

    // Contention: A gives 1<<1=2 (tag 1), B gives 0x10<<1=0x20 (tag 2).
    drive(1'b0, 32'h1, 5'd1, 1'b1, 1'b0, 4'd1);
    drive(1'b1, 32'h10, 5'd1, 1'b1, 1'b0, 4'd2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_b = Rr && (i % 2 == 1);
      check("cont_a_ready", 32'(a_if.ready), 32'(!exp_b));
      check("cont_b_ready", 32'(b_if.ready), 32'(exp_b));
      if (i >= 2) begin
        exp_id = Rr && ((i - 2) % 2 == 1);
        check("cont_rsp_valid", 32'(rsp_valid), 32'd1);
        check("cont_rsp_id", 32'(rsp_id), 32'(exp_id));
        check("cont_rsp_z", rsp_z, exp_id ? 32'h20 : 32'h2);
        check("cont_rsp_tag", 32'(rsp_tag), exp_id ? 32'd2 : 32'd1);
      end
    end
    @(posedge clk); #1;
    a_if.valid = 1'b0;
    b_if.valid = 1'b0;
    repeat (3) @(negedge clk);
    check("cont_drained", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Backpressure: A gives 3<<2=0xC, B gives 0xFFFFFFF0>>>4=0xFFFFFFFF.
    rsp_ready = 1'b0;
    drive(1'b0, 32'h3, 5'd2, 1'b1, 1'b0, 4'd8);
    drive(1'b1, 32'hFFFF_FFF0, 5'd4, 1'b0, 1'b0, 4'd12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ar = a_if.ready;
      br = b_if.ready;
      check("bp_accept", 32'(ar | br), 32'(i < Depth));
      check("bp_onehot", 32'(ar & br), 32'd0);
      @(posedge clk); #1;
      if (ar) a_if.tag = a_if.tag + 4'd1;
      if (br) b_if.tag = b_if.tag + 4'd1;
    end
    bp_z[0] = 32'hC; bp_id[0] = 1'b0; bp_tag[0] = 4'd8;
    if (Rr) begin
      bp_z[1] = 32'hFFFF_FFFF; bp_id[1] = 1'b1; bp_tag[1] = 4'd12;
      bp_z[2] = 32'hC;         bp_id[2] = 1'b0; bp_tag[2] = 4'd9;
    end else begin
      bp_z[1] = 32'hC; bp_id[1] = 1'b0; bp_tag[1] = 4'd9;
      bp_z[2] = 32'hC; bp_id[2] = 1'b0; bp_tag[2] = 4'd10;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_a", 32'(a_if.ready), 32'd1);
    check("bp_resume_b", 32'(b_if.ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        @(posedge clk); #1;
        a_if.valid = 1'b0;
        b_if.valid = 1'b0;
      end
      if (k > 0) @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_z", rsp_z, bp_z[k]);
      check("bp_rsp_id", 32'(rsp_id), 32'(bp_id[k]));
      check("bp_rsp_tag", 32'(rsp_tag), 32'(bp_tag[k]));
    end
    @(negedge clk);
    check("bp_drained", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // Reset with occupancy full (one buffered, one inflight).
    rsp_ready = 1'b0;
    drive(1'b0, 32'h0000_FFFF, 5'd8, 1'b1, 1'b0, 4'd4);
    @(negedge clk);
    check("mr_acc0", 32'(a_if.ready), 32'd1);
    @(negedge clk);
    check("mr_acc1", 32'(a_if.ready), 32'd1);
    @(negedge clk);
    check("mr_full_valid", 32'(rsp_valid), 32'd1);
    check("mr_full_ready", 32'(a_if.ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_async_valid", 32'(rsp_valid), 32'd0);
    check("mr_async_ready", 32'(a_if.ready), 32'd0);
    check("mr_async_z", rsp_z, 32'd0);
    check("mr_async_sh_x", sh_x, 32'd0);
    @(posedge clk); #1;
    a_if.valid = 1'b0;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr_no_stale", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    op_check("post_rst", 1'b0, 32'h0000_FFFF, 5'd8, 1'b1, 1'b0, 4'd4, 32'h00FF_FF00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
